// File: rtl/fifo_ms_write_arbiter_if.sv
// Producer-side handshake and FIFO write/read port bundle for the multi-stream write arbiter.
// The arbiter connects through the slave modport; producers and the FIFO model use master.
interface fifo_ms_write_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2
);
  localparam int TAG_WIDTH = $clog2(FLUX);

  logic [FLUX-1:0]              req_valid;
  logic [FLUX*DATA_WIDTH-1:0]   req_data;
  logic [FLUX-1:0]              req_ready;
  logic [FLUX-1:0]              fifo_read;
  logic                         fifo_write;
  logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_din;

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    input  fifo_read,
    output fifo_write,
    output fifo_din
  );

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    output fifo_read,
    input  fifo_write,
    input  fifo_din
  );
endinterface

// File: rtl/fifo_ms_write_arbiter.sv
// Round-robin, burst-bounded write scheduler merging FLUX producer streams onto one tagged FIFO
// write port, with per-stream occupancy tracking so a full stream is never written.
module fifo_ms_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FLUX       = 2,
  parameter int BURST      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  fifo_ms_write_arbiter_if.slave        bus,
  output logic [$clog2(FLUX)-1:0]       grant_id,
  output logic                          busy,
  output logic [FLUX-1:0]               occ_full,
  output logic                          underflow_err
);

  localparam int TAG_WIDTH  = $clog2(FLUX);
  localparam int OCC_WIDTH  = $clog2(DEPTH + 1);
  localparam int BCNT_WIDTH = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [OCC_WIDTH-1:0]  DEPTH_OCC = OCC_WIDTH'(DEPTH);
  localparam logic [BCNT_WIDTH-1:0] BCNT_LAST = BCNT_WIDTH'(BURST - 1);
  localparam logic [TAG_WIDTH-1:0]  LAST_TAG  = TAG_WIDTH'(FLUX - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state, state_n;
  logic [TAG_WIDTH-1:0]   grant_n;
  logic [TAG_WIDTH-1:0]   rr_ptr, rr_n;
  logic [BCNT_WIDTH-1:0]  bcnt, bcnt_n;
  logic [OCC_WIDTH-1:0]   occ [FLUX];

  logic [FLUX-1:0]        eligible;
  logic [FLUX-1:0]        occ_nz;
  logic [FLUX-1:0]        ready_c;
  logic [FLUX-1:0]        acc_vec;
  logic                   accept;
  logic                   found;
  logic [TAG_WIDTH-1:0]   pick;
  logic [TAG_WIDTH-1:0]   next_ptr;
  logic [DATA_WIDTH-1:0]  grant_data;

  always_comb begin
    eligible = '0;
    occ_full = '0;
    occ_nz   = '0;
    for (int s = 0; s < FLUX; s++) begin
      eligible[s] = bus.req_valid[s] && (occ[s] < DEPTH_OCC);
      occ_full[s] = (occ[s] == DEPTH_OCC);
      occ_nz[s]   = (occ[s] != '0);
    end
  end

  // Ready depends only on registered state so no input reaches an output combinationally.
  always_comb begin
    ready_c = '0;
    if (state == GRANT) begin
      ready_c[grant_id] = (occ[grant_id] < DEPTH_OCC);
    end
  end

  assign bus.req_ready = ready_c;
  assign acc_vec       = bus.req_valid & ready_c;
  assign accept        = |acc_vec;
  assign busy          = (state == GRANT);
  assign grant_data    = bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr      = (grant_id == LAST_TAG) ? '0 : grant_id + 1'b1;

  always_comb begin : rr_search
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < FLUX; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= FLUX) idx = idx - FLUX;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = TAG_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    bcnt_n  = bcnt;
    rr_n    = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          grant_n = pick;
          bcnt_n  = '0;
        end
      end
      GRANT: begin
        if (accept) bcnt_n = bcnt + 1'b1;
        if ((accept && (bcnt == BCNT_LAST)) || !bus.req_valid[grant_id] ||
            (occ[grant_id] == DEPTH_OCC)) begin
          state_n = IDLE;
          rr_n    = next_ptr;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      bcnt     <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_n;
      grant_id <= grant_n;
      bcnt     <= bcnt_n;
      rr_ptr   <= rr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fifo_write <= 1'b0;
      bus.fifo_din   <= '0;
    end else begin
      bus.fifo_write <= accept;
      if (accept) bus.fifo_din <= {grant_id, grant_data};
    end
  end

  // Occupancy counts at acceptance, so the beat still in the output register is already included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < FLUX; s++) occ[s] <= '0;
      underflow_err <= 1'b0;
    end else begin
      for (int s = 0; s < FLUX; s++) begin
        if (acc_vec[s] && !(bus.fifo_read[s] && occ_nz[s])) begin
          occ[s] <= occ[s] + 1'b1;
        end else if (!acc_vec[s] && bus.fifo_read[s] && occ_nz[s]) begin
          occ[s] <= occ[s] - 1'b1;
        end
      end
      underflow_err <= underflow_err | (|(bus.fifo_read & ~occ_nz));
    end
  end

endmodule

// File: doc/fifo_ms_write_arbiter.md
# fifo_ms_write_arbiter

Write-side scheduler for the multi-stream FIFO: merges `FLUX` independent producer streams onto the single tagged write port. It arbitrates round-robin with bounded bursts and tracks per-stream occupancy from its own accepted writes and the FIFO read vector, so it never writes into a full stream. The output is registered and drives the FIFO `write`/`din` directly, with the tag in the MSBs.

## Interface
- `DATA_WIDTH`, 8, payload width per beat
- `DEPTH`, 8, entries per stream in the downstream FIFO; power of 2
- `FLUX`, 2, number of producer streams; must be ≥ 2
- `BURST`, 4, maximum beats per grant; ≥ 1
- Derived: `TAG_WIDTH = $clog2(FLUX)`, `OCC_WIDTH = $clog2(DEPTH+1)`
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset: synchronous, active-high
- `req_valid`  in  FLUX  per-stream beat available
- `req_data`  in  FLUX*DATA_WIDTH  stream s payload at bits `[s*DATA_WIDTH +: DATA_WIDTH]`
- `req_ready`  out  FLUX  per-stream beat accepted this cycle when ANDed with `req_valid`
- `fifo_read`  in  FLUX  one-hot read vector, the same one driven to the FIFO read port
- `fifo_write`  out  1  registered write strobe to the FIFO
- `fifo_din`  out  DATA_WIDTH+TAG_WIDTH  registered `{tag, data}`, with the tag in the MSBs
- `grant_id`  out  TAG_WIDTH  currently granted stream
- `busy`  out  1  high in the GRANT state
- `occ_full`  out  FLUX  per-stream occupancy equals `DEPTH`
- `underflow_err`  out  1  sticky: a read was issued to a stream whose occupancy was 0

## Operation
- **Occupancy.** Each stream has a counter `occ[s]` (OCC_WIDTH bits), updated every cycle:
  - +1 when stream s accepts a beat (`req_valid[s] & req_ready[s]`).
  - −1 when `fifo_read[s]` is high and `occ[s] > 0`.
  - Unchanged when both occur in the same cycle.
  - A read with `occ[s] == 0` leaves the counter at 0 and sets `underflow_err`.
  - Counting at acceptance includes the beat still in the output register, so `occ` is never optimistic.
- **Eligibility.** Stream s is eligible when `req_valid[s] & (occ[s] < DEPTH)`.
- **FSM state IDLE.**
  - Search streams starting at `rr_ptr` and wrapping modulo FLUX.
  - Grant the first eligible stream: `grant_id <= s`, beat counter `bcnt <= 0`, next state GRANT.
  - No eligible stream: remain in IDLE.
  - `req_ready` is all-zero in IDLE.
- **FSM state GRANT (stream g).**
  - `req_ready[g] = (occ[g] < DEPTH)`; all other bits are 0.
  - On acceptance: register `fifo_din <= {g, req_data[g]}` and `fifo_write <= 1`, and increment `bcnt`.
  - Go to IDLE and set `rr_ptr <= (g+1) mod FLUX` when any of the following holds:
    - A beat is accepted with `bcnt == BURST-1`.
    - `req_valid[g] == 0`.
    - `occ[g] == DEPTH`, in which case no beat is accepted.
  - Otherwise stay in GRANT.
- **Output register.** `fifo_write` is 0 in every cycle following a non-accepting cycle. `fifo_din` holds its last value when no beat is accepted.
- **Fairness.** Worst-case wait for an eligible stream is `(FLUX-1)*(BURST+1)` cycles.

## Timing
- **Reset values.** All of the following clear to 0: `fifo_write`, `fifo_din`, `req_ready`, `grant_id`, `busy`, `occ[*]`, `occ_full`, `underflow_err`, `rr_ptr`, `bcnt`. The FSM resets to IDLE.
- **Reset mid-burst.** The grant is dropped immediately and any pending registered beat is discarded (`fifo_write` is 0 in the next cycle). The downstream FIFO is reset by the same `rst`.
- **Arbitration latency.** 1 cycle: `req_valid` rising in cycle t gives `req_ready` in cycle t+1 at the earliest.
- **Write latency.** A beat accepted at edge t appears on `fifo_write`/`fifo_din` during cycle t+1 and is committed by the FIFO at edge t+1.
- **Throughput.** A continuous stream sustains BURST beats per BURST+1 cycles.
- **Backpressure.** `occ` reaching DEPTH on an acceptance edge deasserts `req_ready` in the next cycle, with no overrun. A simultaneous read and accept at DEPTH−1 keeps occ at DEPTH−1, so the next accept is allowed.
- **Combinational paths.** `req_ready` is combinational from registered state (FSM, `grant_id`, `occ`) only. There is no combinational path from `fifo_read` or `req_valid` to any output.

## Test plan
- **Single stream.** FLUX=2, BURST=4; stream 1 holds valid with data 0x10..0x17 → writes `{1,0x10}`..`{1,0x13}`, one idle cycle, then `{1,0x14}`..; `fifo_write` pattern is 1111 0 1111.
- **Round-robin.** Both streams continuously valid → burst of 4 from stream 0, gap, burst of 4 from stream 1, gap, burst from stream 0; tags alternate per burst.
- **Full stream.** DEPTH=8, no reads; stream 0 pushes 10 beats → exactly 8 accepted, `occ_full[0]=1`, `req_ready[0]` stays 0. One `fifo_read=2'b01` → one more beat accepted on a later grant.
- **Simultaneous read/write at DEPTH−1.** occ[0]=7; accept and `fifo_read[0]` in the same cycle → occ stays 7 and the following accept reaches 8.
- **Underflow.** `fifo_read=2'b10` with occ[1]=0 → occ[1] stays 0, `underflow_err` rises next cycle and stays high until `rst`.
- **Reset mid-burst.** `rst` after 2 of 4 beats → next cycle `fifo_write=0`, `busy=0`, all occ=0; after reset release, arbitration restarts at stream 0.
